// File: rtl/cylon_pkg.sv
// cylon_pkg: shared channel state encoding and button index constants for the cylon input front end.
package cylon_pkg;
    typedef enum logic [1:0] {
        IDLE_LO    = 2'd0,
        CONFIRM_HI = 2'd1,
        HELD_HI    = 2'd2,
        CONFIRM_LO = 2'd3
    } ch_state_e;
    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, debounce FSM and saturating counter for one input bit.
module debounce_channel
    import cylon_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CLKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic held_o,
    output logic change_o
);
    localparam int CW = $clog2(DEBOUNCE_CLKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CLKS - 1);
    logic [SYNC_STAGES-1:0] sync_q;
    ch_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic level_q, level_d, press_q, press_d, release_q, release_d, s, done;
    assign s        = sync_q[SYNC_STAGES-1];
    assign done     = cnt_q >= LAST;
    assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign level_o  = level_q;
    assign press_o  = press_q;
    assign release_o = release_q;
    assign held_o   = state_q == HELD_HI;
    // next-cycle strobe, lets the parent register an OR of strobes in the same cycle
    assign change_o = press_d | release_d;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE_LO: if (s) begin
                state_d = CONFIRM_HI;
                cnt_d   = CW'(1);
            end
            CONFIRM_HI: if (!s) begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end else if (done) begin
                state_d = HELD_HI;
                cnt_d   = '0;
                level_d = 1'b1;
                press_d = 1'b1;
            end else cnt_d = cnt_inc;
            HELD_HI: if (!s) begin
                state_d = CONFIRM_LO;
                cnt_d   = CW'(1);
            end
            CONFIRM_LO: if (s) begin
                state_d = HELD_HI;
                cnt_d   = '0;
            end else if (done) begin
                state_d   = IDLE_LO;
                cnt_d     = '0;
                level_d   = 1'b0;
                release_d = 1'b1;
            end else cnt_d = cnt_inc;
            default: state_d = IDLE_LO;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= IDLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces buttons and switches into clean levels and strobes.
// Define BTN_REPEAT_EN to add button auto-repeat press strobes while a button is held.
module button_conditioner
    import cylon_pkg::*;
#(
    parameter int NUM_BUTTONS       = 3,
    parameter int NUM_SWITCHES      = 16,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CLKS     = 1_000_000,
    parameter int REPEAT_DELAY_CLKS = 50_000_000,
    parameter int REPEAT_RATE_CLKS  = 10_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_BUTTONS-1:0]  btn_raw,
    input  logic [NUM_SWITCHES-1:0] sw_raw,
    output logic [NUM_BUTTONS-1:0]  btn_level,
    output logic [NUM_BUTTONS-1:0]  btn_press,
    output logic [NUM_BUTTONS-1:0]  btn_release,
    output logic [NUM_SWITCHES-1:0] sw_stable,
    output logic                    sw_changed
);
    logic [NUM_BUTTONS-1:0]  btn_press_ch, btn_held, btn_chg_unused;
    logic [NUM_SWITCHES-1:0] sw_chg, sw_press_unused, sw_release_unused, sw_held_unused;
    logic sw_changed_q;
    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_ch (
            .clk(clk), .rst_n(rst_n), .raw_i(btn_raw[b]),
            .level_o(btn_level[b]), .press_o(btn_press_ch[b]), .release_o(btn_release[b]),
            .held_o(btn_held[b]), .change_o(btn_chg_unused[b])
        );
    end
    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
        debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_ch (
            .clk(clk), .rst_n(rst_n), .raw_i(sw_raw[i]),
            .level_o(sw_stable[i]), .press_o(sw_press_unused[i]), .release_o(sw_release_unused[i]),
            .held_o(sw_held_unused[i]), .change_o(sw_chg[i])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sw_changed_q <= 1'b0;
        else sw_changed_q <= |sw_chg;
    end
    assign sw_changed = sw_changed_q;
`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY_CLKS + 1);
    localparam logic [RW-1:0] RPT_TOP    = RW'(REPEAT_DELAY_CLKS);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY_CLKS - REPEAT_RATE_CLKS + 1);
    logic [NUM_BUTTONS-1:0][RW-1:0] rpt_q, rpt_d;
    logic [NUM_BUTTONS-1:0] rep_q, rep_d;
    // reaching RPT_TOP fires a repeat, reloading so the next one lands REPEAT_RATE_CLKS later
    always_comb begin
        rpt_d = rpt_q;
        rep_d = '0;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            rpt_d[k] = !btn_held[k] ? '0 : rpt_q[k] == RPT_TOP ? RPT_RELOAD : rpt_q[k] + 1'b1;
            rep_d[k] = btn_held[k] && rpt_d[k] == RPT_TOP;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
            rep_q <= '0;
        end else begin
            rpt_q <= rpt_d;
            rep_q <= rep_d;
        end
    end
    assign btn_press = btn_press_ch | rep_q;
`else
    logic btn_held_unused;
    assign btn_held_unused = ^btn_held;
    assign btn_press = btn_press_ch;
`endif
endmodule
